// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_e;

    localparam int unsigned STEP = 4;

    function automatic logic [1:0] align_mask(input int ialign);
        return (ialign == 16) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target arithmetic, alignment check and prioritised next-PC select.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            trap,
    input  logic            jalr,
    input  logic            pc_src,
    input  logic            advance,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] tvec_masked,
    output logic [XLEN-1:0] bad_target,
    output logic            misalign
);

    localparam logic [1:0] AMASK = align_mask(IALIGN);

    logic [XLEN-1:0] mask_x;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] sel_tgt;

    assign mask_x      = {{(XLEN-2){1'b0}}, AMASK};
    assign br_tgt      = ex_pc + immediate;
    assign jalr_tgt    = {jump_target[XLEN-1:1], 1'b0};
    assign tvec_masked = trap_vector & ~mask_x;

    always_comb begin
        sel_tgt    = jalr ? jalr_tgt : br_tgt;
        next_pc    = pc;
        misalign   = 1'b0;
        bad_target = sel_tgt;
        if (trap) begin
            next_pc = tvec_masked;
        end else if (jalr || pc_src) begin
            // A bad control-flow target diverts straight to the handler.
            if ((sel_tgt & mask_x) != '0) begin
                next_pc  = tvec_masked;
                misalign = 1'b1;
            end else begin
                next_pc = sel_tgt;
            end
        end else if (advance) begin
            next_pc = pc + XLEN'(STEP);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter: BOOT/RUN/HALT control, redirects and
// valid/ready handshake toward instruction memory.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready,
    input  logic            pc_src,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic            run;
    logic [XLEN-1:0] calc_pc;
    logic [XLEN-1:0] tvec_m;
    logic [XLEN-1:0] calc_bad;
    logic            calc_mis;

    assign run = (state_q == ST_RUN);

    // A pending halt freezes sequential advance even if memory accepts.
    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_calc (
        .pc          (pc_q),
        .ex_pc       (ex_pc),
        .immediate   (immediate),
        .jump_target (jump_target),
        .trap_vector (trap_vector),
        .trap        (trap),
        .jalr        (jalr & run),
        .pc_src      (pc_src & run),
        .advance     (run & fetch_ready & ~halt),
        .next_pc     (calc_pc),
        .tvec_masked (tvec_m),
        .bad_target  (calc_bad),
        .misalign    (calc_mis)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                pc_d       = calc_pc;
                misalign_d = calc_mis;
                if (calc_mis) bad_addr_d = calc_bad;
                if (halt) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (trap) begin
                    pc_d    = tvec_m;
                    state_d = ST_RUN;
                end else if (resume && !halt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign halted   = (state_q == ST_HALT);
    assign misalign = misalign_q;
    assign bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: IALIGN=32 and IALIGN=16 instances share stimulus
// and are compared against a behavioural model of the fetch PC.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] immediate = '0;
    logic [31:0] jump_target = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;

    logic [31:0] pc_o [2];
    logic        val_o [2];
    logic        hlt_o [2];
    logic        mis_o [2];
    logic [31:0] bad_o [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pc_sequencer #(
            .XLEN         (32),
            .RESET_VECTOR (RV),
            .IALIGN       (g == 0 ? 32 : 16)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .fetch_ready (fetch_ready),
            .pc_src      (pc_src),
            .jalr        (jalr),
            .ex_pc       (ex_pc),
            .immediate   (immediate),
            .jump_target (jump_target),
            .trap        (trap),
            .trap_vector (trap_vector),
            .halt        (halt),
            .resume      (resume),
            .pc          (pc_o[g]),
            .pc_valid    (val_o[g]),
            .halted      (hlt_o[g]),
            .misalign    (mis_o[g]),
            .bad_addr    (bad_o[g])
        );
    end

    // Model: st 0=boot, 1=run, 2=halt
    typedef struct {
        int          st;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
    } mstate_t;

    mstate_t m [2];

    function automatic mstate_t model_next(mstate_t s, int ialign);
        mstate_t     n;
        int unsigned gran;
        logic [31:0] tv;
        logic [31:0] t;
        n     = s;
        gran  = ialign / 8;
        n.mis = 1'b0;
        tv    = trap_vector - (trap_vector % gran);
        if (s.st == 0) begin
            n.st = 1;
        end else if (s.st == 1) begin
            if (trap) begin
                n.pc = tv;
            end else if (jalr || pc_src) begin
                t = jalr ? (jump_target - (jump_target % 2)) : (ex_pc + immediate);
                if ((t % gran) != 0) begin
                    n.pc = tv; n.mis = 1'b1; n.bad = t;
                end else begin
                    n.pc = t;
                end
            end else if (fetch_ready && !halt) begin
                n.pc = s.pc + 32'd4;
            end
            if (halt) n.st = 2;
        end else begin
            if (trap) begin
                n.pc = tv; n.st = 1;
            end else if (resume && !halt) begin
                n.st = 1;
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{0, RV, 1'b0, 32'h0};
    endtask

    task automatic tick();
        mstate_t n0, n1;
        n0 = model_next(m[0], 32);
        n1 = model_next(m[1], 16);
        @(posedge clk);
        if (reset) begin
            m[0] = n0;
            m[1] = n1;
        end
        #1;
    endtask

    task automatic clear_ctl();
        pc_src = 0; jalr = 0; trap = 0; halt = 0; resume = 0;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        #12;
        checks++; if (pc_o[0] !== RV) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_o[0], RV); end
        checks++; if (val_o[0] !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", val_o[0]); end
        checks++; if (hlt_o[0] !== 1'b0 || mis_o[0] !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", hlt_o[0], mis_o[0]); end
        checks++; if (bad_o[0] !== 32'h0) begin failures++; $display("FAIL rst_bad got=%h exp=0", bad_o[0]); end
        @(posedge clk); #1;
        reset = 1'b1;
        fetch_ready = 1'b1;
        checks++; if (val_o[0] !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", val_o[0]); end
        tick();
        checks++; if (pc_o[0] !== 32'h100 || val_o[0] !== 1'b1) begin failures++; $display("FAIL first_fetch got=%h/%b exp=100/1", pc_o[0], val_o[0]); end
        tick();
        checks++; if (pc_o[0] !== 32'h104) begin failures++; $display("FAIL seq1 got=%h exp=104", pc_o[0]); end
        tick();
        checks++; if (pc_o[0] !== 32'h108) begin failures++; $display("FAIL seq2 got=%h exp=108", pc_o[0]); end
    endtask

    task automatic test_stall();
        jalr = 1; jump_target = 32'h20;
        tick();
        jalr = 0; fetch_ready = 0;
        checks++; if (pc_o[0] !== 32'h20) begin failures++; $display("FAIL stall_go got=%h exp=20", pc_o[0]); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_o[0] !== 32'h20 || val_o[0] !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h/%b exp=20/1", pc_o[0], val_o[0]); end
        end
        fetch_ready = 1;
        tick();
        checks++; if (pc_o[0] !== 32'h24) begin failures++; $display("FAIL stall_adv got=%h exp=24", pc_o[0]); end
    endtask

    task automatic test_priority();
        trap_vector = 32'h800; jump_target = 32'h400;
        ex_pc = 32'h10; immediate = 32'h20;
        trap = 1; jalr = 1; pc_src = 1;
        tick();
        checks++; if (pc_o[0] !== 32'h800) begin failures++; $display("FAIL prio_trap got=%h exp=800", pc_o[0]); end
        trap = 0;
        tick();
        checks++; if (pc_o[0] !== 32'h400) begin failures++; $display("FAIL prio_jalr got=%h exp=400", pc_o[0]); end
        jalr = 0;
        tick();
        checks++; if (pc_o[0] !== 32'h30) begin failures++; $display("FAIL prio_br got=%h exp=30", pc_o[0]); end
        clear_ctl();
    endtask

    task automatic test_misalign();
        trap_vector = 32'h800; fetch_ready = 0;
        jalr = 1; jump_target = 32'h1003;
        tick();
        jalr = 0;
        checks++; if (pc_o[0] !== 32'h800 || mis_o[0] !== 1'b1) begin failures++; $display("FAIL mis32 got=%h/%b exp=800/1", pc_o[0], mis_o[0]); end
        checks++; if (bad_o[0] !== 32'h1002) begin failures++; $display("FAIL mis32_bad got=%h exp=1002", bad_o[0]); end
        checks++; if (pc_o[1] !== 32'h1002 || mis_o[1] !== 1'b0) begin failures++; $display("FAIL mis16 got=%h/%b exp=1002/0", pc_o[1], mis_o[1]); end
        tick();
        checks++; if (mis_o[0] !== 1'b0 || bad_o[0] !== 32'h1002) begin failures++; $display("FAIL mis_pulse got=%b/%h exp=0/1002", mis_o[0], bad_o[0]); end
        pc_src = 1; ex_pc = 32'h10; immediate = 32'h2;
        tick();
        pc_src = 0;
        checks++; if (mis_o[0] !== 1'b1 || bad_o[0] !== 32'h12) begin failures++; $display("FAIL mis_br got=%b/%h exp=1/12", mis_o[0], bad_o[0]); end
        checks++; if (pc_o[1] !== 32'h12) begin failures++; $display("FAIL mis_br16 got=%h exp=12", pc_o[1]); end
    endtask

    task automatic test_halt();
        jalr = 1; jump_target = 32'h40; fetch_ready = 1;
        tick();
        jalr = 0; halt = 1;
        tick();
        checks++; if (hlt_o[0] !== 1'b1 || val_o[0] !== 1'b0 || pc_o[0] !== 32'h40) begin failures++; $display("FAIL halt_in got=%b/%b/%h exp=1/0/40", hlt_o[0], val_o[0], pc_o[0]); end
        halt = 0; pc_src = 1; ex_pc = 32'h10; immediate = 32'h20;
        tick();
        checks++; if (pc_o[0] !== 32'h40 || hlt_o[0] !== 1'b1) begin failures++; $display("FAIL halt_ign got=%h/%b exp=40/1", pc_o[0], hlt_o[0]); end
        pc_src = 0; resume = 1;
        tick();
        checks++; if (val_o[0] !== 1'b1 || pc_o[0] !== 32'h40 || hlt_o[0] !== 1'b0) begin failures++; $display("FAIL resume got=%b/%h exp=1/40", val_o[0], pc_o[0]); end
        resume = 0; fetch_ready = 0; halt = 1;
        tick();
        resume = 1;
        tick();
        checks++; if (hlt_o[0] !== 1'b1) begin failures++; $display("FAIL halt_resume got=%b exp=1", hlt_o[0]); end
        halt = 0; resume = 0; trap = 1; trap_vector = 32'h803;
        tick();
        trap = 0;
        checks++; if (pc_o[0] !== 32'h800 || val_o[0] !== 1'b1 || pc_o[1] !== 32'h802) begin failures++; $display("FAIL halt_trap got=%h/%h/%b exp=800/802/1", pc_o[0], pc_o[1], val_o[0]); end
        checks++; if (mis_o[0] !== 1'b0) begin failures++; $display("FAIL trap_nomis got=%b exp=0", mis_o[0]); end
    endtask

    task automatic test_wrap();
        jalr = 1; jump_target = 32'hFFFF_FFFC; fetch_ready = 1;
        tick();
        jalr = 0;
        checks++; if (pc_o[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=fffffffc", pc_o[0]); end
        tick();
        checks++; if (pc_o[0] !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", pc_o[0]); end
    endtask

    task automatic test_async_reset();
        fetch_ready = 0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (pc_o[0] !== RV || val_o[0] !== 1'b0 || pc_o[1] !== RV) begin failures++; $display("FAIL async_rst got=%h/%b exp=100/0", pc_o[0], val_o[0]); end
        @(posedge clk); #1;
        reset = 1'b1;
        fetch_ready = 1;
        tick();
        checks++; if (val_o[0] !== 1'b1 || pc_o[0] !== RV) begin failures++; $display("FAIL rst_reboot got=%b/%h exp=1/100", val_o[0], pc_o[0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fetch_ready = ($urandom_range(3) != 0);
            trap        = ($urandom_range(15) == 0);
            jalr        = ($urandom_range(7) == 0);
            pc_src      = ($urandom_range(7) == 0);
            halt        = ($urandom_range(15) == 0);
            resume      = ($urandom_range(3) == 0);
            ex_pc       = $urandom & 32'h0000_FFFC;
            immediate   = $urandom_range(1) ? 32'($urandom_range(63)) : -32'($urandom_range(63));
            jump_target = $urandom;
            trap_vector = $urandom;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (pc_o[i] !== m[i].pc || val_o[i] !== (m[i].st == 1) ||
                    hlt_o[i] !== (m[i].st == 2) || mis_o[i] !== m[i].mis ||
                    bad_o[i] !== m[i].bad) begin
                    failures++;
                    $display("FAIL rand[%0d] c=%0d got=%h/%b/%b/%b/%h exp=%h/%b/%b/%b/%h",
                             i, c, pc_o[i], val_o[i], hlt_o[i], mis_o[i], bad_o[i],
                             m[i].pc, m[i].st == 1, m[i].st == 2, m[i].mis, m[i].bad);
                end
            end
        end
        clear_ctl();
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_misalign();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
